sfx_scheduler: RTL and testbench
================================

Name: sfx_scheduler

Overview:
- Shares one square-wave tone path among NUM_REQ sound-effect requesters: countdown, hit, miss and combo cues.
- Latches each request's pitch and duration, then grants the tone path by fixed priority. Index 0 has the highest priority.
- Times playback, inserts an inter-sound gap, and outputs the signed 32-bit sample that the top level adds to both audio-out channels.
- Sits between the game FSMs and the Audio_Controller write path.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- HP_W, 19, width of a half-period value in CLOCK_50 cycles.
- DUR_W, 32, width of a duration value in CLOCK_50 cycles.
- GAP_CYCLES, 15000000, silent cycles after each sound ends or is aborted (≥1).
- AMPLITUDE, 50000000, sample magnitude.

Ports:
- CLOCK_50  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- req  in  NUM_REQ  one-cycle request pulse per requester
- req_half_period  in  NUM_REQ*HP_W  per-requester half period, slice i = [i*HP_W +: HP_W]
- req_duration  in  NUM_REQ*DUR_W  per-requester duration, slice i = [i*DUR_W +: DUR_W]
- mute  in  1  forces the sample to 0; timing continues
- grant  out  NUM_REQ  one-hot, one-cycle pulse when a requester starts playing
- done  out  NUM_REQ  one-hot, one-cycle pulse when a sound completes or is aborted
- busy  out  1  high in PLAY or GAP
- active_id  out  3  index of the playing or last-played requester
- sound  out  32  signed sample

Behaviour:
- Reset (async, resetn=0): state=IDLE; pending=0; grant=0; done=0; busy=0; active_id=0; sound=0; all counters 0.
- Request capture:
  - req[i]=1 in cycle t with duration slice ≠0 → pending[i]=1 and half_period/duration latched from t+1.
  - Duration 0 → request dropped; no grant, no done.
  - Half period 0 is latched as 1.
  - req[i] while pending[i]=1 overwrites the latched values; one sound only.
- States:
  - IDLE:
    - Stays IDLE while pending=0.
    - When pending≠0, choose the lowest index k.
    - Next edge: state=PLAY, grant[k]=1 for one cycle, active_id=k, pending[k] cleared, dur_cnt=duration_k, hp_cnt=half_period_k, snd=1.
    - Request to grant latency is 2 cycles (req at t → grant and first nonzero sound at t+2).
  - PLAY:
    - hp_cnt decrements each cycle; at 1, reload and toggle snd.
    - dur_cnt decrements each cycle; sound is nonzero for exactly duration_k cycles.
    - After the last cycle: state=GAP, done[k]=1 for one cycle, gap_cnt=GAP_CYCLES.
  - GAP:
    - sound=0; gap_cnt decrements; at 1 → IDLE.
    - The next grant can come at the earliest 1 cycle after entering IDLE.
- Sample: sound = +AMPLITUDE if snd, else −AMPLITUDE (two's complement). It is 0 outside PLAY or when mute=1. Registered, aligned with state.
- Simultaneous events:
  - req[k] in the same cycle pending[k] is cleared by grant → set wins and the request stays pending.
  - req[k] for the currently playing k → queued and replayed after the GAP.
  - Multiple req in one cycle → all latched, served in index order.
- busy=1 in PLAY and GAP.
- Mid-operation reset returns everything to reset values with no done pulse. Outputs return to reset values immediately; they do not wait for a clock edge.

Optional Feature:
- Macro: SFX_PREEMPT_EN.
- Defined:
  - In PLAY, if pending[j]=1 with j<active_id, the current sound aborts on the next edge.
  - done[active_id] pulses, the state goes to GAP with gap_cnt=GAP_CYCLES, and the aborted request is not re-queued.
  - A request arriving during GAP never preempts.
- Undefined: PLAY always runs to completion; priority applies only in IDLE.

Test Plan:
- Reset, then req[1] with half_period=4, duration=20 → grant[1] 2 cycles later; sound pattern +A×4, −A×4, …, 20 nonzero cycles; done[1] on the next cycle; busy lasts 20+GAP_CYCLES; then IDLE.
- req[2] and req[0] in the same cycle (GAP_CYCLES=10 in bench) → grant[0] first, grant[2] exactly 1 cycle after GAP ends.
- req[3] with duration=0 → no grant, no done, busy stays 0; half_period=0, duration=6 → sound alternates sign every cycle.
- mute=1 during a 16-cycle sound → sound=0 throughout; done still at cycle 16; grant/done timing unchanged.
- SFX_PREEMPT_EN: req[0] arrives during PLAY of id 2 → done[2] next cycle, GAP, then grant[0]. Without the macro: id 2 plays the full duration first.
- resetn low mid-PLAY → sound, busy and pending are 0 immediately; no done pulse; a fresh req[1] after reset plays normally.

Source files
------------

// File: rtl/sfx_scheduler.sv
// sfx_scheduler: shares one square-wave tone path among NUM_REQ sound-effect
// requesters (countdown, hit, miss, combo cues). Each request latches its own
// pitch and duration, the tone path is granted by fixed priority (index 0
// highest), and every sound is followed by a silent gap of GAP_CYCLES.
// The signed sample output is added to both audio channels by the top level.
//
// Optional build macro: SFX_PREEMPT_EN
//   defined   -> a pending higher-priority request aborts the sound in PLAY
//   undefined -> PLAY always runs to completion; priority only matters in IDLE
module sfx_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int HP_W       = 19,
  parameter int DUR_W      = 32,
  parameter int GAP_CYCLES = 15000000,
  parameter int AMPLITUDE  = 50000000
) (
  input  logic                      CLOCK_50,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*HP_W-1:0]   req_half_period,
  input  logic [NUM_REQ*DUR_W-1:0]  req_duration,
  input  logic                      mute,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic                      busy,
  output logic [2:0]                active_id,
  output logic [31:0]               sound
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'(GAP_CYCLES);
  localparam logic [31:0]        AMP_POS  = 32'(AMPLITUDE);
  localparam logic [31:0]        AMP_NEG  = 32'(-AMPLITUDE);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_GAP
  } state_t;

  // Per-requester views of the packed input buses
  logic [HP_W-1:0]    hp_in [NUM_REQ];
  logic [DUR_W-1:0]   dur_in [NUM_REQ];
  logic [NUM_REQ-1:0] req_valid;

  // Latched request parameters and pending flags
  logic [HP_W-1:0]    hp_lat_reg [NUM_REQ];
  logic [DUR_W-1:0]   dur_lat_reg [NUM_REQ];
  logic [NUM_REQ-1:0] pending_reg;

  // Playback state
  state_t             state_reg;
  logic [NUM_REQ-1:0] grant_reg;
  logic [NUM_REQ-1:0] done_reg;
  logic               busy_reg;
  logic [IDX_W-1:0]   active_idx_reg;
  logic [31:0]        sound_reg;
  logic [DUR_W-1:0]   dur_cnt_reg;
  logic [HP_W-1:0]    hp_cnt_reg;
  logic [HP_W-1:0]    hp_play_reg;
  logic [GAP_W-1:0]   gap_cnt_reg;
  logic               snd_reg;

  // Arbitration and tone helpers
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_fire;
  logic               preempt;
  logic               hp_wrap;
  logic               snd_next;

  // A zero-duration request is silently dropped, so it never becomes valid
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign hp_in[gi]     = req_half_period[gi*HP_W +: HP_W];
      assign dur_in[gi]    = req_duration[gi*DUR_W +: DUR_W];
      assign req_valid[gi] = req[gi] && (dur_in[gi] != '0);
    end
  endgenerate

  // Fixed-priority pick: lowest pending index wins
  always_comb begin
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pending_reg[i]) grant_idx = IDX_W'(i);
    end
  end

  assign grant_fire = (state_reg == ST_IDLE) && (pending_reg != '0);

`ifdef SFX_PREEMPT_EN
  // Any pending request with a smaller index than the playing one aborts it
  always_comb begin
    preempt = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pending_reg[i] && (IDX_W'(i) < active_idx_reg)) preempt = 1'b1;
    end
  end
`else
  assign preempt = 1'b0;
`endif

  // Square-wave phase: toggle when the half-period counter expires
  assign hp_wrap  = (hp_cnt_reg == HP_W'(1));
  assign snd_next = hp_wrap ? ~snd_reg : snd_reg;

  function automatic logic [31:0] sample_of(input logic s);
    return s ? AMP_POS : AMP_NEG;
  endfunction

  // Latch pitch/duration of each accepted request; half period 0 plays as 1
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        hp_lat_reg[i]  <= '0;
        dur_lat_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i]) begin
          hp_lat_reg[i]  <= (hp_in[i] == '0) ? HP_W'(1) : hp_in[i];
          dur_lat_reg[i] <= dur_in[i];
        end
      end
    end
  end

  // Pending flags: a new request beats the clear caused by its own grant
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      pending_reg <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i]) begin
          pending_reg[i] <= 1'b1;
        end else if (grant_fire && (grant_idx == IDX_W'(i))) begin
          pending_reg[i] <= 1'b0;
        end
      end
    end
  end

  // Playback FSM with all outputs registered alongside the state
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= '0;
      done_reg       <= '0;
      busy_reg       <= 1'b0;
      active_idx_reg <= '0;
      sound_reg      <= '0;
      dur_cnt_reg    <= '0;
      hp_cnt_reg     <= '0;
      hp_play_reg    <= '0;
      gap_cnt_reg    <= '0;
      snd_reg        <= 1'b0;
    end else begin
      grant_reg <= '0;
      done_reg  <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (grant_fire) begin
            state_reg      <= ST_PLAY;
            grant_reg      <= ONE_HOT0 << grant_idx;
            active_idx_reg <= grant_idx;
            dur_cnt_reg    <= dur_lat_reg[grant_idx];
            hp_cnt_reg     <= hp_lat_reg[grant_idx];
            hp_play_reg    <= hp_lat_reg[grant_idx];
            snd_reg        <= 1'b1;
            busy_reg       <= 1'b1;
            sound_reg      <= mute ? '0 : AMP_POS;
          end else begin
            busy_reg  <= 1'b0;
            sound_reg <= '0;
          end
        end

        ST_PLAY: begin
          if (preempt || (dur_cnt_reg == DUR_W'(1))) begin
            state_reg   <= ST_GAP;
            done_reg    <= ONE_HOT0 << active_idx_reg;
            gap_cnt_reg <= GAP_LOAD;
            dur_cnt_reg <= '0;
            hp_cnt_reg  <= '0;
            snd_reg     <= 1'b0;
            sound_reg   <= '0;
          end else begin
            dur_cnt_reg <= dur_cnt_reg - DUR_W'(1);
            hp_cnt_reg  <= hp_wrap ? hp_play_reg : (hp_cnt_reg - HP_W'(1));
            snd_reg     <= snd_next;
            sound_reg   <= mute ? '0 : sample_of(snd_next);
          end
        end

        ST_GAP: begin
          sound_reg <= '0;
          if (gap_cnt_reg == GAP_W'(1)) begin
            state_reg   <= ST_IDLE;
            busy_reg    <= 1'b0;
            gap_cnt_reg <= '0;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          sound_reg <= '0;
        end
      endcase
    end
  end

  assign grant     = grant_reg;
  assign done      = done_reg;
  assign busy      = busy_reg;
  assign active_id = 3'(active_idx_reg);
  assign sound     = sound_reg;

endmodule

// File: tb/tb_sfx_scheduler.sv
// tb_sfx_scheduler: directed bench for sfx_scheduler with a cycle-stamped
// scoreboard. Stimulus pushes the expected per-cycle output of every sound
// (grant, samples, done, gap) and a monitor pops one entry whenever the DUT
// shows activity. GAP_CYCLES is shortened to 10.
module tb_sfx_scheduler;

  localparam int NUM_REQ = 4;
  localparam int HP_W    = 19;
  localparam int DUR_W   = 32;
  localparam int GAP     = 10;
  localparam logic signed [31:0] AMP = 32'sd50000000;

  logic                     CLOCK_50 = 1'b0;
  logic                     resetn   = 1'b0;
  logic [NUM_REQ-1:0]       req      = '0;
  logic [NUM_REQ*HP_W-1:0]  req_half_period = '0;
  logic [NUM_REQ*DUR_W-1:0] req_duration    = '0;
  logic                     mute     = 1'b0;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic                     busy;
  logic [2:0]               active_id;
  logic [31:0]              sound;

  sfx_scheduler #(
    .NUM_REQ(NUM_REQ), .HP_W(HP_W), .DUR_W(DUR_W),
    .GAP_CYCLES(GAP), .AMPLITUDE(50000000)
  ) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .req(req),
    .req_half_period(req_half_period), .req_duration(req_duration),
    .mute(mute), .grant(grant), .done(done), .busy(busy),
    .active_id(active_id), .sound(sound)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic [31:0] sound;
    logic [2:0]  id;
  } exp_t;

  exp_t exp_q[$];
  int   checks      = 0;
  int   failures    = 0;
  int   present_cnt = 0;

  // Monitor: every cycle with visible activity must match the next entry
  always @(negedge CLOCK_50) begin
    exp_t e;
    if (resetn && (busy || grant != '0 || done != '0 || sound != '0)) begin
      present_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output cyc=%0d grant=%b done=%b busy=%b sound=%0d",
                 cyc, grant, done, busy, $signed(sound));
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.grant != grant || e.done != done ||
            e.sound != sound || e.id != active_id || busy !== 1'b1) begin
          failures++;
          $display("FAIL entry actual: cyc=%0d grant=%b done=%b sound=%0d id=%0d busy=%b required: cyc=%0d grant=%b done=%b sound=%0d id=%0d busy=1",
                   cyc, grant, done, $signed(sound), active_id, busy,
                   e.cyc, e.grant, e.done, $signed(e.sound), e.id);
        end else if (e.done != '0) begin
          $display("txn id=%0d done at cyc=%0d", e.id, cyc);
        end
      end
    end
  end

  // Expected trace of one sound: play_len sample cycles then GAP silent cycles
  task automatic push_play(input int id, input int hp, input int start,
                           input int play_len, input bit muted);
    exp_t e;
    int   h;
    h = (hp == 0) ? 1 : hp;
    for (int n = 0; n < play_len; n++) begin
      e.cyc   = start + n;
      e.grant = (n == 0) ? 4'(1 << id) : 4'b0;
      e.done  = 4'b0;
      e.sound = muted ? 32'd0 : ((((n / h) % 2) == 0) ? AMP : -AMP);
      e.id    = 3'(id);
      exp_q.push_back(e);
    end
    for (int m = 0; m < GAP; m++) begin
      e.cyc   = start + play_len + m;
      e.grant = 4'b0;
      e.done  = (m == 0) ? 4'(1 << id) : 4'b0;
      e.sound = 32'd0;
      e.id    = 3'(id);
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic load(input int id, input int hp, input int dur);
    req[id] = 1'b1;
    req_half_period[id*HP_W +: HP_W] = HP_W'(hp);
    req_duration[id*DUR_W +: DUR_W]  = DUR_W'(dur);
  endtask

  // Hold the loaded requests for exactly one cycle; c is that cycle
  task automatic fire(output int c);
    c = cyc;
    step();
    req = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) step();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s timeout actual_left=%0d required_left=0", name, exp_q.size());
      exp_q.delete();
    end
    step();
  endtask

  task automatic expect_quiet(input string name, input int n);
    int p0;
    p0 = present_cnt;
    repeat (n) step();
    chk(name, 32'(present_cnt - p0), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c, c2, s, c0;

    // Reset values
    repeat (2) @(posedge CLOCK_50);
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_active_id", 32'(active_id), 32'd0);
    chk("rst_sound", sound, 32'd0);
    resetn = 1'b1;
    repeat (2) step();

    // Basic sound: hp 4, 20 cycles, grant 2 cycles after the request
    load(1, 4, 20);
    fire(c);
    push_play(1, 4, c + 2, 20, 0);
    wait_drain("basic");

    // Two requests together: id 0 first, id 2 one cycle after its gap
    load(0, 3, 8);
    load(2, 2, 5);
    fire(c);
    push_play(0, 3, c + 2, 8, 0);
    push_play(2, 2, c + 2 + 8 + GAP + 1, 5, 0);
    wait_drain("pair");

    // Zero duration is dropped; half period 0 alternates every cycle
    load(3, 7, 0);
    fire(c);
    expect_quiet("drop_zero_dur", 12);
    load(3, 0, 6);
    fire(c);
    push_play(3, 0, c + 2, 6, 0);
    wait_drain("hp_zero");

    // Mute keeps timing but silences the sample
    mute = 1'b1;
    load(1, 5, 16);
    fire(c);
    push_play(1, 5, c + 2, 16, 1);
    wait_drain("mute");
    mute = 1'b0;
    step();

    // Higher-priority request arriving while id 2 plays
    load(2, 3, 12);
    fire(c);
    s  = c + 2;
    c0 = c + 5;
`ifdef SFX_PREEMPT_EN
    push_play(2, 3, s, c0 + 2 - s, 0);
    push_play(0, 2, c0 + 2 + GAP + 1, 4, 0);
`else
    push_play(2, 3, s, 12, 0);
    push_play(0, 2, s + 12 + GAP + 1, 4, 0);
`endif
    repeat (4) step();
    load(0, 2, 4);
    fire(c2);
    chk("preempt_req_cycle", 32'(c2), 32'(c0));
    wait_drain("priority_in_play");

    // Re-request of the id being granted: set wins, replayed after the gap
    load(1, 2, 4);
    fire(c);
    s = c + 2;
    push_play(1, 2, s, 4, 0);
    push_play(1, 1, s + 4 + GAP + 1, 3, 0);
    load(1, 1, 3);
    fire(c2);
    wait_drain("replay_same_id");

    // Reset in the middle of a sound with another request pending
    load(1, 4, 30);
    fire(c);
    push_play(1, 4, c + 2, 30, 0);
    load(2, 3, 5);
    fire(c2);
    repeat (4) step();
    resetn = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_sound", sound, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_active_id", 32'(active_id), 32'd0);
    chk("midrst_pending", 32'(dut.pending_reg), 32'd0);
    repeat (3) step();
    resetn = 1'b1;
    expect_quiet("post_reset_quiet", 15);
    load(1, 3, 7);
    fire(c);
    push_play(1, 3, c + 2, 7, 0);
    wait_drain("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
